// File: rtl/sdh_regs_pkg.sv
// Shared constants and types for the SD host register
// access sequencer.
package sdh_regs_pkg;

  localparam int NUM_REQ     = 3;
  localparam int TIMEOUT_DEF = 15;

  localparam logic [7:0] ADDR_000H = 8'h00;
  localparam logic [7:0] ADDR_004H = 8'h04;
  localparam logic [7:0] ADDR_006H = 8'h06;
  localparam logic [7:0] ADDR_008H = 8'h08;
  localparam logic [7:0] ADDR_00EH = 8'h0E;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    WAIT,
    DONE,
    ERR
  } state_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin picker; the pointer advances only
// when the sequencer retires a transaction.
module rr_arbiter3
  import sdh_regs_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               upd,
  input  logic [1:0]         owner,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         idx
);

  logic [1:0] ptr_q, ptr_d;
  logic       hit;

  always_comb begin
    ptr_d = ptr_q;
    if (upd) begin
      ptr_d = (owner == 2'd2) ? 2'd0 : owner + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Search starts at the pointer and wraps 0 -> 1 -> 2.
  always_comb begin
    hit = 1'b0;
    idx = 2'd0;
    gnt = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!hit && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        hit = 1'b1;
        idx = 2'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
    if (hit) begin
      gnt = 3'b001 << idx;
    end
  end

endmodule

// File: rtl/reg_access_sequencer.sv
// Arbitrates register writes from three requesters, pulses
// one enable, then waits for the register's ack.
module reg_access_sequencer
  import sdh_regs_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 5,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      enb_block0,
  output logic                      enb_block1,
  output logic                      enb_block2,
  output logic [NUM_REGS-1:0]       reg_sel,
  output logic [DATA_W-1:0]         wr_data,
  input  logic [NUM_REGS-1:0]       reg_ack,
  output logic                      busy
);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [1:0]          own_q, own_d;
  logic [NUM_REGS-1:0] sel_q, sel_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic [3:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [1:0]          arb_idx;
  logic                ptr_upd;
  logic [ADDR_W-1:0]   addr_in;
  logic [DATA_W-1:0]   wdata_in;
  logic [NUM_REGS-1:0] sel_dec;

  rr_arbiter3 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .upd   (ptr_upd),
    .owner (own_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx)
  );

  always_comb begin
    addr_in  = req_addr[arb_idx*ADDR_W +: ADDR_W];
    wdata_in = req_wdata[arb_idx*DATA_W +: DATA_W];
    sel_dec  = '0;
    unique case (1'b1)
      (addr_in == ADDR_W'(ADDR_000H)): sel_dec[0] = 1'b1;
      (addr_in == ADDR_W'(ADDR_004H)): sel_dec[1] = 1'b1;
      (addr_in == ADDR_W'(ADDR_006H)): sel_dec[2] = 1'b1;
      (addr_in == ADDR_W'(ADDR_008H)): sel_dec[3] = 1'b1;
      (addr_in == ADDR_W'(ADDR_00EH)): sel_dec[4] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    sel_d   = sel_q;
    wdat_d  = wdat_q;
    cnt_d   = cnt_q;
    ptr_upd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d = arb_gnt;
          own_d = arb_idx;
          if (|sel_dec) begin
            sel_d   = sel_dec;
            wdat_d  = wdata_in;
            state_d = DRIVE;
          end else begin
            state_d = ERR;
          end
        end
      end
      DRIVE: begin
        cnt_d   = 4'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (|(reg_ack & sel_q)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == 4'(TIMEOUT)) begin
            state_d = ERR;
          end
        end
      end
      DONE, ERR: begin
        gnt_d   = '0;
        sel_d   = '0;
        wdat_d  = '0;
        ptr_upd = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      own_q   <= 2'd0;
      sel_q   <= '0;
      wdat_q  <= '0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = (state_q == DONE) ? gnt_q : '0;
  assign err        = (state_q == ERR) ? gnt_q : '0;
  assign enb_block0 = (state_q == DRIVE) & gnt_q[0];
  assign enb_block1 = (state_q == DRIVE) & gnt_q[1];
  assign enb_block2 = (state_q == DRIVE) & gnt_q[2];
  assign reg_sel    = sel_q;
  assign wr_data    = wdat_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Directed and random writes against a transaction-level
// model of arbitration, decode and ack timing.
module tb_reg_access_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [23:0] req_addr;
  logic [95:0] req_wdata;
  logic [2:0]  gnt, done, err;
  logic        enb_block0, enb_block1, enb_block2;
  logic [4:0]  reg_sel, reg_ack;
  logic [31:0] wr_data;
  logic        busy;

  int n_chk   = 0;
  int n_fail  = 0;
  int exp_ptr = 0;
  int lag_cfg = 0;
  int lag_cnt = 0;

  logic [31:0] mem [5] = '{default: '0};
  logic [7:0]  offs [5] = '{8'h00, 8'h04, 8'h06, 8'h08, 8'h0E};

  reg_access_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .enb_block0 (enb_block0),
    .enb_block1 (enb_block1),
    .enb_block2 (enb_block2),
    .reg_sel    (reg_sel),
    .wr_data    (wr_data),
    .reg_ack    (reg_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Register file: captures on any enable, acks once its
  // stored value matches the bus and lag_cfg cycles passed.
  always @(posedge clk) begin
    if (enb_block0 | enb_block1 | enb_block2) begin
      for (int i = 0; i < 5; i++) begin
        if (reg_sel[i]) mem[i] <= wr_data;
      end
      lag_cnt <= lag_cfg;
    end else if (lag_cnt > 0) begin
      lag_cnt <= lag_cnt - 1;
    end
  end

  always_comb begin
    reg_ack = '0;
    for (int i = 0; i < 5; i++) begin
      reg_ack[i] = (lag_cnt == 0) && (mem[i] == wr_data);
    end
  end

  function automatic int sel_of(input logic [7:0] a);
    for (int i = 0; i < 5; i++) begin
      if (offs[i] == a) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 64'(busy), 64'(0));
    chk({tag, " gnt"}, 64'(gnt), 64'(0));
    chk({tag, " done"}, 64'(done), 64'(0));
    chk({tag, " err"}, 64'(err), 64'(0));
    chk({tag, " enb"},
        64'({enb_block2, enb_block1, enb_block0}), 64'(0));
    chk({tag, " sel"}, 64'(reg_sel), 64'(0));
    chk({tag, " wdata"}, 64'(wr_data), 64'(0));
  endtask

  task automatic rand_ops(input bit all_valid);
    for (int i = 0; i < 3; i++) begin
      if (!all_valid && $urandom_range(0, 3) == 0)
        req_addr[i*8 +: 8] = 8'($urandom);
      else
        req_addr[i*8 +: 8] = offs[$urandom_range(0, 4)];
      req_wdata[i*32 +: 32] = $urandom;
    end
  endtask

  // One transaction from an idle DUT; lag > 14 never acks.
  task automatic txn(input logic [2:0] rq,
                     input int lag,
                     input bit wiggle);
    int own, si, fin;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [2:0]  oh, ex_en, ex_dn, ex_er;
    logic [4:0]  se;
    req = rq;
    own = -1;
    for (int k = 0; k < 3; k++) begin
      if (own < 0 && rq[(exp_ptr + k) % 3])
        own = (exp_ptr + k) % 3;
    end
    a  = req_addr[own*8 +: 8];
    wd = req_wdata[own*32 +: 32];
    si = sel_of(a);
    oh = 3'(1 << own);
    se = (si < 0) ? 5'd0 : 5'(1 << si);
    lag_cfg = lag;
    if (si < 0) fin = 1;
    else if (lag <= 14) fin = 3 + lag;
    else fin = 17;
    for (int c = 1; c <= fin + 1; c++) begin
      step();
      if (c == 1 && wiggle) begin
        req_addr[own*8 +: 8]    = 8'($urandom);
        req_wdata[own*32 +: 32] = $urandom;
        if ($urandom_range(0, 2) == 0) req[own] = 1'b0;
      end
      if (c > fin) begin
        chk_idle("retired");
      end else begin
        ex_en = (c == 1 && si >= 0) ? oh : 3'd0;
        ex_dn = (c == fin && si >= 0 && lag <= 14)
                ? oh : 3'd0;
        ex_er = (c == fin && (si < 0 || lag > 14))
                ? oh : 3'd0;
        chk("busy", 64'(busy), 64'(1));
        chk("gnt", 64'(gnt), 64'(oh));
        chk("enb",
            64'({enb_block2, enb_block1, enb_block0}),
            64'(ex_en));
        chk("reg_sel", 64'(reg_sel), 64'(se));
        if (si >= 0) chk("wr_data", 64'(wr_data), 64'(wd));
        chk("done", 64'(done), 64'(ex_dn));
        chk("err", 64'(err), 64'(ex_er));
      end
    end
    exp_ptr = (own + 1) % 3;
  endtask

  initial begin
    rst = 1'b0;
    req = 3'b111;
    req_addr = '0;
    req_wdata = '0;
    rand_ops(1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("reset");
    end
    rst = 1'b1;

    // Held contention from reset: 0,1,2,0.
    for (int i = 0; i < 4; i++) txn(3'b111, 0, 1'b0);

    req_addr[8 +: 8]   = 8'h08;
    req_wdata[32 +: 32] = 32'hDEADBEEF;
    txn(3'b010, 0, 1'b0);

    req_addr[16 +: 8] = 8'h05;
    txn(3'b100, 0, 1'b0);

    req_addr[0 +: 8] = 8'h04;
    txn(3'b001, 99, 1'b0);

    for (int n = 0; n < 40; n++) begin
      rand_ops(1'b0);
      txn(3'($urandom_range(1, 7)),
          ($urandom_range(0, 9) == 0)
            ? 15 : $urandom_range(0, 4),
          1'b1);
    end

    // Abort in WAIT with the pointer away from 0.
    req = '0;
    step();
    req_addr[0 +: 8] = 8'h0E;
    txn(3'b001, 0, 1'b0);
    req = 3'b001;
    lag_cfg = 99;
    for (int c = 0; c < 4; c++) step();
    chk("pre-abort busy", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    chk_idle("abort");
    step();
    rst = 1'b1;
    req = '0;
    exp_ptr = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_idle("post-abort");
    end
    rand_ops(1'b1);
    txn(3'b111, 0, 1'b0);

    req = '0;
    step();
    step();
    chk_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_access_sequencer.md
Name: reg_access_sequencer

Overview:
- Shares the SD host register set (reg_000h, reg_004h, reg_006h, reg_008h, command register at 0x0E) among three requesters (0 = host bus, 1 = DMA engine, 2 = command engine).
- Round-robin arbitration per transaction; decodes the register offset.
- Drives exactly one enb_blockN so the register's XOR enable fires, then holds write data until that register's ack confirms the value.
- Reports done or err to the requester; a timeout guards a register that never acks.

Parameters:
- ADDR_W, 8, register offset width
- DATA_W, 32, write data width (narrower registers use the low bits)
- NUM_REGS, 5, registers served
- TIMEOUT, 15, maximum WAIT cycles before err (4-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req  in  3  per-requester write request; held until done/err
- req_addr  in  3*ADDR_W  offsets; slice i belongs to requester i
- req_wdata  in  3*DATA_W  write data; slice i belongs to requester i
- gnt  out  3  one-hot, the current owner
- done  out  3  one-cycle pulse to the owner on successful write
- err  out  3  one-cycle pulse to the owner on bad address or timeout
- enb_block0  out  1  write enable, requester-0 path
- enb_block1  out  1  write enable, requester-1 path
- enb_block2  out  1  write enable, requester-2 path
- reg_sel  out  NUM_REGS  one-hot register select
- wr_data  out  DATA_W  data bus to registers
- reg_ack  in  NUM_REGS  ack from each register (data_in == data_out)
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst = 0, async):
  - state IDLE, rr pointer = 0, timeout counter = 0.
  - gnt, done, err, enb_block*, reg_sel, wr_data, busy all 0.
- Address decode:
  - 0x00 → reg_sel[0]; 0x04 → [1]; 0x06 → [2]; 0x08 → [3]; 0x0E → [4].
  - Any other offset is invalid.
- FSM states: IDLE, DRIVE, WAIT, DONE, ERR.
- IDLE:
  - If req != 0, pick the first set bit starting at the rr pointer and cycling 0→1→2.
  - Register gnt, address and wdata.
  - Valid address → DRIVE; invalid address → ERR.
- DRIVE (exactly 1 cycle):
  - enb_block[owner] = 1, all other enb_block* = 0.
  - reg_sel and wr_data valid; the register captures at the end of this cycle.
  - → WAIT; counter cleared.
- WAIT:
  - enb_block* = 0; reg_sel and wr_data held stable.
  - reg_ack is sampled only in WAIT, never in DRIVE.
  - reg_ack[sel] = 1 → DONE.
  - Else counter++; if counter == TIMEOUT → ERR.
- DONE / ERR (1 cycle each):
  - done[owner] or err[owner] = 1.
  - rr pointer = owner + 1 (mod 3).
  - reg_sel, wr_data, gnt cleared → IDLE.
- Latency: req seen in IDLE at cycle N → enb at N+1 → ack sampled at N+2 → done at N+3 → IDLE at N+4. Minimum 4 cycles per transaction.
- Back-to-back: a req still high in IDLE starts a new transaction; a requester must drop req on the cycle after done/err or it will be re-granted.
- req deasserted mid-transaction: ignored; the transaction completes and done/err is still pulsed.
- Changes to req_addr/req_wdata after grant: ignored (latched copy used).
- Simultaneous requests: strict rotation. With all three held, grant order from reset is 0, 1, 2, 0, …
- Invariant: at most one enb_block* high in any cycle, and only in DRIVE.
- Reset mid-transaction: immediate return to the reset state; no done/err is issued for the aborted write.

Decomposition:
- Package sdh_regs_pkg:
  - register offset constants (ADDR_000H … ADDR_00EH)
  - state enum (IDLE, DRIVE, WAIT, DONE, ERR)
  - NUM_REQ = 3, TIMEOUT default
- Sub-module rr_arbiter3: pointer-based 3-way round-robin picker. Combinational select plus a pointer-update input from the FSM.

Test Plan:
- Reset: rst = 0 with req = 3'b111 → all outputs 0, busy 0; release → first gnt = 3'b001.
- Single write: req[1] = 1, addr 0x08, wdata 0xDEADBEEF, model reg acks on the cycle after enb → enb_block1 high exactly 1 cycle, reg_sel = 5'b01000, done[1] pulses at N+3.
- Contention: req = 3'b111 held, all acks prompt → gnt sequence 001, 010, 100, 001; never two enb_block* high in the same cycle.
- Bad address: req[2] = 1, addr 0x05 → err[2] pulses at N+1; enb_block* and reg_sel stay 0.
- Timeout: req[0], addr 0x04, reg_ack held 0 → err[0] after 15 WAIT cycles; reg_sel held the whole time, then cleared.
- Mid-op reset: assert rst = 0 during WAIT → outputs 0 immediately; after release the pointer is 0 and no stale done/err appears.
